// File: rtl/clk_meas_pkg.sv
// Shared types and helpers for the clock period meter.
// Optional feature macro used by the meter: CLK_METER_DUTY_MEAS_EN.
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } meas_state_t;

    // All-ones value for a counter of the given width.
    function automatic logic [31:0] cnt_max(input int unsigned width);
        logic [32:0] one_sh;
        one_sh = 33'd1 << width;
        return 32'(one_sh - 33'd1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer for the measured signal plus rise/fall pulse generation.
// CLK_METER_DUTY_MEAS_EN adds the level and fall outputs for high-time logic.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
`ifdef CLK_METER_DUTY_MEAS_EN
    output logic s,
    output logic fall,
`endif
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s_dly_q;
    logic                   s_dly_d;
    logic                   s_w;

    assign s_w = sync_q[SYNC_STAGES-1];

    // Shift chain input and one-cycle delayed copy of the synced level
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_dly_d = s_w;
    end

    // Synchronizer and delay flops
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign rise = s_w & ~s_dly_q;

`ifdef CLK_METER_DUTY_MEAS_EN
    assign s    = s_w;
    assign fall = ~s_w & s_dly_q;
`endif

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow signal in clk_in cycles.
// CLK_METER_DUTY_MEAS_EN enables high-time measurement and its use in lock.
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CMAX = CNT_W'(cnt_max(CNT_W));
    localparam int               MW   = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic [MW-1:0]    match_q, match_d;
    logic [CNT_W-1:0] hlat_w;
    logic             same_meas;
    logic             rise;

`ifdef CLK_METER_DUTY_MEAS_EN
    logic             s;
    logic             fall;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] hlat_q, hlat_d;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .reset (reset),
        .sig_in(sig_in),
        .s     (s),
        .fall  (fall),
        .rise  (rise)
    );

    // High-time counter restarts on rise; latched when the signal falls
    always_comb begin
        hcnt_d = hcnt_q;
        hlat_d = hlat_q;
        if (rise) begin
            hcnt_d = CNT_W'(1);
        end else if (s && hcnt_q != CMAX) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
        if (fall) begin
            hlat_d = hcnt_q;
        end
    end

    // High-time counter and latch registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            hcnt_q <= '0;
            hlat_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            hlat_q <= hlat_d;
        end
    end

    assign hlat_w    = hlat_q;
    assign same_meas = (cnt_q == period_q) && (hlat_q == high_q);
    assign high_time = high_q;
`else
    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .reset (reset),
        .sig_in(sig_in),
        .rise  (rise)
    );

    assign hlat_w    = '0;
    assign same_meas = (cnt_q == period_q);
    assign high_time = '0;
`endif

    // Period counter: restarts on rise, saturates while measuring
    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == MEASURE && cnt_q != CMAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Next state, measurement update, lock tracking and timeout
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        high_d    = high_q;
        mv_d      = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        match_d   = match_q;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    period_d = cnt_q;
                    high_d   = hlat_w;
                    mv_d     = 1'b1;
                    if (match_q == '0 || !same_meas) begin
                        match_d = MW'(1);
                    end else if (match_q != LOCK_V) begin
                        match_d = match_q + MW'(1);
                    end
                    locked_d = (match_d == LOCK_V);
                end else if (cnt_q == CMAX) begin
                    state_d   = TIMEOUT;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    match_d   = '0;
                end
            end
            TIMEOUT: begin
                if (rise) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and output registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            mv_q      <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            mv_q      <= mv_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
        end
    end

    assign period     = period_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with an edge-timestamp reference model.
// Expectations follow CLK_METER_DUTY_MEAS_EN when it is defined.
module tb_clk_period_meter;

    localparam int CNT_W = 8;
    localparam int LOCK  = 4;
    localparam int SS    = 2;
    localparam int CMAX  = 255;
    localparam int HMAX  = 8192;
`ifdef CLK_METER_DUTY_MEAS_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             reset  = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             locked;
    logic             timeout;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .LOCK_CNT   (LOCK),
        .SYNC_STAGES(SS)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: timestamps of synced edges, plain arithmetic
    logic hist [0:HMAX-1];
    int   e = 0;
    int   m_state = 0;  // 0 idle, 1 measuring, 2 timed out
    int   m_last_rise = 0;
    int   m_hlat = 0;
    int   m_period = 0;
    int   m_high = 0;
    int   m_mv = 0;
    int   m_locked = 0;
    int   m_timeout = 0;
    int   m_match = 0;

    // observers for literal checks
    int   watch = 0;
    int   widx = 0;
    int   first_lock = -1;
    int   wlock_at = 0;
    int   mv_cnt = 0;
    int   last_mv_e = 0;
    int   to_rise_e = 0;
    int   to_fall_e = 0;
    int   mv_after_fall = 0;
    logic prev_to = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    function automatic int hget(input int i);
        if (i < 0) return 0;
        return int'(hist[i]);
    endfunction

    task automatic model_edge(input logic sv, input logic rv);
        int w, wp, np, nh;
        bit eq;
        e++;
        if (e >= HMAX) begin
            $display("FAIL hist_overflow: got %0d, want <%0d", e, HMAX);
            $fatal(1);
        end
        hist[e] = sv;
        m_mv = 0;
        if (rv) begin
            for (int i = e - SS; i <= e; i++) if (i >= 0) hist[i] = 1'b0;
            m_state = 0; m_last_rise = 0; m_hlat = 0;
            m_period = 0; m_high = 0; m_locked = 0;
            m_timeout = 0; m_match = 0;
            return;
        end
        w  = hget(e - SS);
        wp = hget(e - SS - 1);
        if (w == 0 && wp == 1) m_hlat = e - m_last_rise;
        if (w == 1 && wp == 0) begin
            if (m_state == 1) begin
                np = e - m_last_rise;
                nh = DUTY ? m_hlat : 0;
                eq = (np == m_period) && (!DUTY || nh == m_high);
                if (m_match == 0 || !eq) m_match = 1;
                else if (m_match < LOCK) m_match++;
                m_locked = (m_match == LOCK);
                m_period = np;
                m_high = nh;
                m_mv = 1;
            end else begin
                m_timeout = 0;
            end
            m_state = 1;
            m_last_rise = e;
        end else if (m_state == 1 && e - m_last_rise == CMAX) begin
            m_state = 2;
            m_timeout = 1;
            m_locked = 0;
            m_match = 0;
        end
    endtask

    task automatic step(input logic sv, input logic rv);
        sig_in = sv;
        reset  = rv;
        @(posedge clk_in);
        model_edge(sv, rv);
        @(negedge clk_in);
        check("period", int'(period), m_period);
        check("high_time", int'(high_time), m_high);
        check("meas_valid", int'(meas_valid), m_mv);
        check("locked", int'(locked), m_locked);
        check("timeout", int'(timeout), m_timeout);
        if (meas_valid) begin
            mv_cnt++;
            last_mv_e = e;
            if (to_fall_e > 0 && mv_after_fall == 0) mv_after_fall = e;
            if (int'(period) == watch) begin
                widx++;
                if (widx == 1) first_lock = int'(locked);
                if (locked && wlock_at == 0) wlock_at = widx;
            end
        end
        if (timeout && !prev_to) to_rise_e = e;
        if (!timeout && prev_to) to_fall_e = e;
        prev_to = timeout;
    endtask

    task automatic wave(input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) step(1'b1, 1'b0);
            for (int j = 0; j < lo; j++) step(1'b0, 1'b0);
        end
    endtask

    task automatic set_watch(input int p);
        watch = p; widx = 0; first_lock = -1; wlock_at = 0;
    endtask

    initial begin
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        check("rst_period", int'(period), 0);
        check("rst_locked", int'(locked), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

        // 4 high / 5 low
        set_watch(9);
        wave(4, 5, 7);
        check("t1_lock_at", wlock_at, 4);
        check("t1_first_lock", first_lock, 0);
        check("t1_period", int'(period), 9);
        check("t1_high", int'(high_time), DUTY ? 4 : 0);

        // 3 high / 4 low after lock
        set_watch(7);
        wave(3, 4, 7);
        check("t2_drop", first_lock, 0);
        check("t2_relock_at", wlock_at, 4);

        // hold low into timeout, then resume
        step(1'b0, 1'b0);
        to_fall_e = 0; mv_after_fall = 0;
        for (int i = 0; i < 270; i++) step(1'b0, 1'b0);
        check("t3_to_delay", to_rise_e - last_mv_e, 255);
        check("t3_timeout", int'(timeout), 1);
        check("t3_locked", int'(locked), 0);
        check("t3_hold_period", int'(period), 7);
        wave(4, 5, 3);
        check("t3_first_mv", mv_after_fall - to_fall_e, 9);
        check("t3_cleared", int'(timeout), 0);

        // reset in the middle of a high phase
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("t4_period", int'(period), 0);
        check("t4_high", int'(high_time), 0);
        check("t4_mv", int'(meas_valid), 0);
        check("t4_locked", int'(locked), 0);
        check("t4_timeout", int'(timeout), 0);
        mv_cnt = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        wave(4, 5, 1);
        check("t4_no_first_mv", mv_cnt, 0);
        wave(4, 5, 1);
        check("t4_second_mv", mv_cnt, 1);
        wave(4, 5, 2);

        // minimum period
        set_watch(2);
        wave(1, 1, 8);
        check("t5_first_lock", first_lock, 0);
        check("t5_lock_at", wlock_at, 4);
        check("t5_period", int'(period), 2);
        check("t5_high", int'(high_time), DUTY ? 1 : 0);

        // period 9 with alternating duty
        for (int k = 0; k < 6; k++) begin
            wave(3, 6, 1);
            wave(6, 3, 1);
        end
        check("t6_period", int'(period), 9);
        check("t6_locked", int'(locked), DUTY ? 0 : 1);
        if (!DUTY) check("t6_high", int'(high_time), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
